// File: rtl/sync_arith_pkg.sv
// Shared opcodes, flag bundle and saturation-limit helper for the
// sync_arith_pipe add/sub/accumulate pipeline.
package sync_arith_pkg;

  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_SUB     = 2'b01;
  localparam logic [1:0] OP_ACC     = 2'b10;
  localparam logic [1:0] OP_ACC_CLR = 2'b11;

  // Widest datapath the saturation helper can describe.
  localparam int MAX_WIDTH = 64;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
  } flags_t;

  // Saturation value for a signed number of the given width:
  // 1000...0 when negative, 0111...1 otherwise. Callers size-cast the result.
  function automatic logic [MAX_WIDTH-1:0] sat_limit(input int width, input logic negative);
    logic [MAX_WIDTH-1:0] msb;
    msb = {{(MAX_WIDTH-1){1'b0}}, 1'b1} << (width - 1);
    return negative ? msb : msb - {{(MAX_WIDTH-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/addsub_flags.sv
// Combinational add/subtract with raw carry, signed overflow, optional
// signed saturation and a zero flag on the final result.
module addsub_flags
  import sync_arith_pkg::*;
#(
  parameter int dataWidth = 8
) (
  input  logic [dataWidth-1:0] a,
  input  logic [dataWidth-1:0] b,
  input  logic                 subtract,
  input  logic                 satMode,
  output logic [dataWidth-1:0] result,
  output logic                 carry,
  output logic                 overflow,
  output logic                 zero
);

  logic [dataWidth-1:0] b_eff;
  logic [dataWidth-1:0] raw_sum;
  logic [dataWidth-1:0] sat_val;

  // Subtraction is a + ~b + 1, so carry = 1 means no borrow.
  assign b_eff = subtract ? ~b : b;
  assign {carry, raw_sum} = {1'b0, a} + {1'b0, b_eff} + {{dataWidth{1'b0}}, subtract};

  assign overflow = (a[dataWidth-1] == b_eff[dataWidth-1]) &&
                    (raw_sum[dataWidth-1] != a[dataWidth-1]);

  assign sat_val = dataWidth'(sat_limit(dataWidth, a[dataWidth-1]));
  assign result  = (satMode && overflow) ? sat_val : raw_sum;
  assign zero    = ~|result;

endmodule

// File: rtl/sync_arith_pipe.sv
// Two-stage valid/ready pipeline: S1 registers operands, S2 registers the
// add/sub/accumulate result and flags. dataWidth must be 2 or more.
module sync_arith_pipe
  import sync_arith_pkg::*;
#(
  parameter int dataWidth = 8,
  parameter bit hasAcc    = 1'b1
) (
  input  logic                 pipeClock,
  input  logic                 resetPos,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [dataWidth-1:0] numA,
  input  logic [dataWidth-1:0] numB,
  input  logic [1:0]           opSelect,
  input  logic                 satMode,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [dataWidth-1:0] resultOut,
  output logic                 carryOut,
  output logic                 overflowBit,
  output logic                 zeroFlag
);

  // Stage 1: captured operands.
  logic                 s1_valid_q, s1_valid_d;
  logic [dataWidth-1:0] s1_a_q, s1_a_d;
  logic [dataWidth-1:0] s1_b_q, s1_b_d;
  logic [1:0]           s1_op_q, s1_op_d;
  logic                 s1_sat_q, s1_sat_d;

  // Stage 2: computed result.
  logic                 s2_valid_q, s2_valid_d;
  logic [dataWidth-1:0] s2_result_q, s2_result_d;
  flags_t               s2_flags_q, s2_flags_d;

  logic [dataWidth-1:0] acc_q;

  logic                 s2_advance;
  logic                 accept;

  // Handshake: S1 frees up when empty or when it moves into S2 this cycle.
  assign s2_advance = s1_valid_q & (~s2_valid_q | outReady);
  assign inReady    = ~s1_valid_q | s2_advance;
  assign accept     = inValid & inReady;

  // Operand routing: accumulate ops add numA onto the accumulator.
  logic                 use_acc;
  logic                 is_clr;
  logic [dataWidth-1:0] alu_a, alu_b;
  logic [dataWidth-1:0] alu_result;
  logic                 alu_carry, alu_overflow, alu_zero;

  assign use_acc = hasAcc & s1_op_q[1];
  assign is_clr  = use_acc & (s1_op_q == OP_ACC_CLR);
  assign alu_a   = use_acc ? acc_q  : s1_a_q;
  assign alu_b   = use_acc ? s1_a_q : s1_b_q;

  addsub_flags #(
    .dataWidth (dataWidth)
  ) u_addsub (
    .a        (alu_a),
    .b        (alu_b),
    .subtract (s1_op_q == OP_SUB),
    .satMode  (s1_sat_q),
    .result   (alu_result),
    .carry    (alu_carry),
    .overflow (alu_overflow),
    .zero     (alu_zero)
  );

  logic [dataWidth-1:0] fin_result;
  flags_t               fin_flags;

  always_comb begin
    // NOTE: every combinational output gets a default first so that no path
    // leaves it unassigned; an unassigned path infers a latch.
    fin_result         = alu_result;
    fin_flags.carry    = alu_carry;
    fin_flags.overflow = alu_overflow;
    fin_flags.zero     = alu_zero;
    if (is_clr) begin
      fin_result         = s1_a_q;
      fin_flags.carry    = 1'b0;
      fin_flags.overflow = 1'b0;
      fin_flags.zero     = ~|s1_a_q;
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_op_d     = s1_op_q;
    s1_sat_d    = s1_sat_q;
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_flags_d  = s2_flags_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_a_d     = numA;
      s1_b_d     = numB;
      s1_op_d    = opSelect;
      s1_sat_d   = satMode;
    end else if (s2_advance) begin
      s1_valid_d = 1'b0;
    end

    // S2 only changes on advance, so a stalled result holds its value.
    if (s2_advance) begin
      s2_valid_d  = 1'b1;
      s2_result_d = fin_result;
      s2_flags_d  = fin_flags;
    end else if (outReady) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge pipeClock or posedge resetPos) begin
    if (resetPos) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_op_q     <= OP_ADD;
      s1_sat_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_flags_q  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every register
      // samples its _d value from before this edge, independent of order.
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_op_q     <= s1_op_d;
      s1_sat_q    <= s1_sat_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_flags_q  <= s2_flags_d;
    end
  end

  generate
    if (hasAcc) begin : g_acc
      logic [dataWidth-1:0] acc_d;

      // Loaded on the edge the accumulate beat enters S2, so the next beat
      // sitting in S1 already sees the updated value.
      assign acc_d = (s2_advance && use_acc) ? fin_result : acc_q;

      always_ff @(posedge pipeClock or posedge resetPos) begin
        if (resetPos) begin
          acc_q <= '0;
        end else begin
          acc_q <= acc_d;
        end
      end
    end else begin : g_no_acc
      assign acc_q = '0;
    end
  endgenerate

  assign outValid    = s2_valid_q;
  assign resultOut   = s2_result_q;
  assign carryOut    = s2_flags_q.carry;
  assign overflowBit = s2_flags_q.overflow;
  assign zeroFlag    = s2_flags_q.zero;

endmodule

// File: tb/tb_sync_arith_pipe.sv
// Scoreboard bench for sync_arith_pipe: one instance with the accumulator,
// one without, fed the same stream and checked against an integer model.
module tb_sync_arith_pipe;
  import sync_arith_pkg::*;

  logic       pipe_clock = 1'b0;
  logic       reset_pos;
  logic       in_valid;
  logic [7:0] num_a, num_b;
  logic [1:0] op_select;
  logic       sat_mode;
  logic       out_ready;

  logic       in_ready,  out_valid,  carry_out,  overflow_bit,  zero_flag;
  logic [7:0] result_out;
  logic       in_ready_n, out_valid_n, carry_out_n, overflow_bit_n, zero_flag_n;
  logic [7:0] result_out_n;

  always #5 pipe_clock = ~pipe_clock;

  sync_arith_pipe #(.dataWidth(8), .hasAcc(1'b1)) dut (
    .pipeClock (pipe_clock), .resetPos (reset_pos),
    .inValid (in_valid), .inReady (in_ready),
    .numA (num_a), .numB (num_b), .opSelect (op_select), .satMode (sat_mode),
    .outValid (out_valid), .outReady (out_ready),
    .resultOut (result_out), .carryOut (carry_out),
    .overflowBit (overflow_bit), .zeroFlag (zero_flag)
  );

  sync_arith_pipe #(.dataWidth(8), .hasAcc(1'b0)) dut_na (
    .pipeClock (pipe_clock), .resetPos (reset_pos),
    .inValid (in_valid), .inReady (in_ready_n),
    .numA (num_a), .numB (num_b), .opSelect (op_select), .satMode (sat_mode),
    .outValid (out_valid_n), .outReady (out_ready),
    .resultOut (result_out_n), .carryOut (carry_out_n),
    .overflowBit (overflow_bit_n), .zeroFlag (zero_flag_n)
  );

  typedef struct packed {
    logic [7:0] r;
    logic       c;
    logic       v;
    logic       z;
  } beat_t;

  typedef struct packed {
    beat_t acc;
    beat_t noacc;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   acc_model    = 0;
  bit   stim_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic on unsigned 0..255 operands using true signed math.
  function automatic beat_t arith(input int x, input int y, input bit sub, input bit sat);
    int    sx, sy, ts;
    bit    ovf;
    beat_t f;
    sx  = (x > 127) ? x - 256 : x;
    sy  = (y > 127) ? y - 256 : y;
    ts  = sub ? sx - sy : sx + sy;
    ovf = (ts > 127) || (ts < -128);
    f.c = sub ? (x >= y) : ((x + y) > 255);
    f.v = ovf;
    if (sat && ovf) f.r = (ts > 127) ? 8'h7F : 8'h80;
    else            f.r = ts[7:0];
    f.z = (f.r == 8'h00);
    return f;
  endfunction

  function automatic logic [7:0] pick();
    logic [7:0] corners [5];
    corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return 8'($urandom);
  endfunction

  // Presents one beat; expected values are pushed the cycle it is accepted.
  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input logic [1:0] op, input logic sat);
    int    waited;
    exp_t  e;
    waited    = 0;
    in_valid  = 1'b1;
    num_a     = a;
    num_b     = b;
    op_select = op;
    sat_mode  = sat;
    forever begin
      @(negedge pipe_clock);
      if (in_ready) break;
      waited++;
      if (waited > 200) begin
        check("send_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    check("in_ready_match", 32'(in_ready_n), 32'(in_ready));
    e.noacc = arith(int'(a), int'(b), op == OP_SUB, sat);
    case (op)
      OP_ADD, OP_SUB: e.acc = e.noacc;
      OP_ACC: begin
        e.acc     = arith(acc_model, int'(a), 1'b0, sat);
        acc_model = int'(e.acc.r);
      end
      default: begin
        e.acc     = '{r: a, c: 1'b0, v: 1'b0, z: (a == 8'h00)};
        acc_model = int'(a);
      end
    endcase
    sb_q.push_back(e);
    @(posedge pipe_clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((sb_q.size() != 0 || out_valid) && n < 100) begin
      @(negedge pipe_clock);
      n++;
    end
    check("drain_empty", 32'(sb_q.size()), 32'd0);
    @(posedge pipe_clock);
    #1;
  endtask

  // Monitor: pops on every output transfer, checks holding while stalled.
  initial begin
    beat_t held;
    bit    held_v;
    exp_t  e;
    held_v = 1'b0;
    forever begin
      @(negedge pipe_clock);
      if (reset_pos) begin
        held_v = 1'b0;
      end else if (out_valid && out_ready) begin
        held_v = 1'b0;
        if (sb_q.size() == 0) begin
          check("extra_output", 32'(out_valid), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("beat_acc", 32'({result_out, carry_out, overflow_bit, zero_flag}), 32'(e.acc));
          check("noacc_valid", 32'(out_valid_n), 32'd1);
          check("beat_noacc", 32'({result_out_n, carry_out_n, overflow_bit_n, zero_flag_n}),
                32'(e.noacc));
        end
      end else if (out_valid) begin
        if (held_v)
          check("hold_stable", 32'({result_out, carry_out, overflow_bit, zero_flag}), 32'(held));
        held   = '{r: result_out, c: carry_out, v: overflow_bit, z: zero_flag};
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d checks run", tests_run);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_pos = 1'b1;
    in_valid  = 1'b0;
    num_a     = 8'h00;
    num_b     = 8'h00;
    op_select = OP_ADD;
    sat_mode  = 1'b0;
    out_ready = 1'b1;
    stim_done = 1'b0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_outputs", 32'({result_out, carry_out, overflow_bit, zero_flag}), 32'd0);
    #20 reset_pos = 1'b0;
    @(posedge pipe_clock);
    #1;

    // Overflow with and without saturation, plus first-beat latency.
    send(8'h7F, 8'h01, OP_ADD, 1'b0);
    @(negedge pipe_clock);
    check("latency_early", 32'(out_valid), 32'd0);
    @(posedge pipe_clock);
    #1;
    check("latency_valid", 32'(out_valid), 32'd1);
    send(8'h7F, 8'h01, OP_ADD, 1'b1);
    send(8'h05, 8'h05, OP_SUB, 1'b0);
    send(8'h80, 8'h01, OP_SUB, 1'b1);
    send(8'h00, 8'h01, OP_SUB, 1'b0);

    // Back-to-back accumulate chain, then saturating accumulate.
    send(8'h0A, 8'h33, OP_ACC_CLR, 1'b0);
    send(8'h14, 8'h44, OP_ACC, 1'b0);
    send(8'h1E, 8'h55, OP_ACC, 1'b0);
    send(8'h50, 8'h66, OP_ACC, 1'b1);
    drain();

    // Six beats against a four-cycle output stall.
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(pick(), pick(), 2'($urandom_range(0, 3)), 1'($urandom));
      end
      begin
        repeat (3) @(negedge pipe_clock);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        @(negedge pipe_clock);
        @(posedge pipe_clock);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Accumulate beat held in S1 behind a stalled S2.
    out_ready = 1'b0;
    send(8'h10, 8'h00, OP_ACC_CLR, 1'b0);
    send(8'h01, 8'h00, OP_ACC, 1'b0);
    repeat (3) @(posedge pipe_clock);
    #1;
    out_ready = 1'b1;
    send(8'h00, 8'h00, OP_ACC, 1'b0);
    drain();

    // Asynchronous reset with both stages full.
    out_ready = 1'b0;
    send(pick(), pick(), OP_ACC, 1'b0);
    send(pick(), pick(), OP_ADD, 1'b0);
    #2;
    reset_pos = 1'b1;
    #1;
    check("midrst_out_valid", 32'({out_valid, out_valid_n}), 32'd0);
    check("midrst_outputs", 32'({result_out, carry_out, overflow_bit, zero_flag}), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    sb_q.delete();
    acc_model = 0;
    @(posedge pipe_clock);
    #3 reset_pos = 1'b0;
    out_ready = 1'b1;
    @(posedge pipe_clock);
    #1;
    send(8'h03, 8'h21, OP_ACC, 1'b0);
    drain();

    // Random stream under random backpressure.
    fork
      begin
        for (int i = 0; i < 300; i++) send(pick(), pick(), 2'($urandom_range(0, 3)), 1'($urandom));
        stim_done = 1'b1;
      end
      begin
        while (!stim_done) begin
          @(posedge pipe_clock);
          #1;
          out_ready = ($urandom_range(0, 9) < 7);
        end
      end
    join
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
